// File: rtl/sat_accum_adder.sv
// Registered unsigned add/sub/accumulate/load unit with optional saturation,
// sticky overflow flag, transaction counter and a one-entry valid/ready output stage.
module sat_accum_adder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SATURATE  = 1,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 carry,
  output logic                 sat_seen,
  output logic [CNT_WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    ModeAdd  = 2'b00,
    ModeSub  = 2'b01,
    ModeAcc  = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [WIDTH-1:0]     r_result;
  logic                 r_carry;
  logic                 r_sat_seen;
  logic [CNT_WIDTH-1:0] r_count;
  logic [WIDTH-1:0]     r_acc;

  mode_e                w_mode;
  logic                 w_acc_fire;
  logic                 w_out_fire;
  logic [WIDTH:0]       w_sum;
  logic                 w_carry;
  logic [WIDTH-1:0]     w_final;

  assign w_mode     = mode_e'(mode);
  assign out_valid  = (r_state == StFull);
  // Ready looks straight through to out_ready so a held result can be swapped in one edge.
  assign in_ready   = !out_valid || out_ready;
  assign w_acc_fire = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  assign result   = r_result;
  assign carry    = r_carry;
  assign sat_seen = r_sat_seen;
  assign count    = r_count;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEmpty: if (w_acc_fire) w_state_next = StFull;
      StFull:  if (w_out_fire && !w_acc_fire) w_state_next = StEmpty;
      default: w_state_next = StEmpty;
    endcase
  end

  // Bit WIDTH of the extended sum is the raw carry (ADD/ACC) or borrow (SUB).
  always_comb begin
    w_sum = '0;
    unique case (w_mode)
      ModeAdd:  w_sum = {1'b0, a} + {1'b0, b};
      ModeSub:  w_sum = {1'b0, a} - {1'b0, b};
      ModeAcc:  w_sum = {1'b0, r_acc} + {1'b0, a};
      ModeLoad: w_sum = {1'b0, a};
      default:  w_sum = '0;
    endcase
  end

  assign w_carry = w_sum[WIDTH];

  always_comb begin
    w_final = w_sum[WIDTH-1:0];
    if ((SATURATE != 0) && w_carry) begin
      w_final = (w_mode == ModeSub) ? '0 : '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StEmpty;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_sat_seen <= 1'b0;
      r_count    <= '0;
      r_acc      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_acc_fire) begin
        r_result <= w_final;
        r_carry  <= w_carry;
        r_count  <= r_count + CNT_WIDTH'(1);
        if (w_mode == ModeLoad) begin
          r_sat_seen <= 1'b0;
        end else if (w_carry) begin
          r_sat_seen <= 1'b1;
        end
        if ((w_mode == ModeAcc) || (w_mode == ModeLoad)) begin
          r_acc <= w_final;
        end
      end
    end
  end

endmodule

// File: doc/sat_accum_adder.md
Name: sat_accum_adder

Overview:
Parametrised successor to the fixed 8-bit combinational pad adder. Registered unsigned arithmetic unit: add, subtract, running accumulate and accumulator load, with optional saturation, carry/borrow flags and a transaction counter. It uses a valid/ready handshake on input and output, with a one-entry output register. It sits between the dedicated input pins (ui_in/uio_in) and the output pins (uo_out) inside the tile top level.

Parameters:
WIDTH, 8, operand/result/accumulator width in bits (>=2)
SATURATE, 1, 1 = clamp results on carry/borrow; 0 = wrap modulo 2^WIDTH
CNT_WIDTH, 8, width of the accepted-transaction counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand/mode presented
in_ready  output  1  block can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored in ACC/LOAD)
mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD
out_valid  output  1  result register holds unconsumed result
out_ready  input  1  consumer takes result this cycle
result  output  WIDTH  registered result
carry  output  1  raw carry-out (ADD/ACC) or borrow (SUB) of the accepted op; 0 for LOAD
sat_seen  output  1  sticky: a saturation or wrap event occurred since reset/LOAD
count  output  CNT_WIDTH  number of accepted transactions, modulo 2^CNT_WIDTH

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset, sampled on a clk edge: out_valid=0, result=0, carry=0, sat_seen=0, count=0, accumulator=0. in_ready=1 during the cycle following reset.
- Reset mid-operation discards any held result. No partial state survives, and rst overrides every simultaneous handshake.
- Accept condition: acc_fire = in_valid & in_ready. Consume condition: out_fire = out_valid & out_ready.
- in_ready = !out_valid | out_ready. This is combinational from out_ready, giving full throughput with no bubble.
- Output FSM, two states:
  - EMPTY (out_valid=0): acc_fire -> FULL.
  - FULL (out_valid=1): out_fire & !acc_fire -> EMPTY; out_fire & acc_fire -> FULL with new data; otherwise hold.
- Latency: 1 cycle. An op accepted at edge N shows result/carry at edge N with out_valid=1.
- result and carry are stable while out_valid=1 and out_ready=0.
- Arithmetic is unsigned. Compute in WIDTH+1 bits; bit WIDTH is the raw carry/borrow.
- Per mode:
  - ADD: s = a+b.
  - SUB: s = a-b, where borrow = (a<b).
  - ACC: s = acc+a. The accumulator register is updated with the final (clamped or wrapped) result.
  - LOAD: s = a. The accumulator is set to a, carry=0, and sat_seen is cleared.
- SATURATE=1: ADD/ACC with carry gives result=all-ones; SUB with borrow gives result=0.
- SATURATE=0: result = low WIDTH bits of s.
- sat_seen is set on any accepted op with carry/borrow=1, in either SATURATE setting.
- The accumulator changes only on acc_fire in ACC or LOAD; ADD and SUB leave it untouched.
- count increments by 1 on each acc_fire, wrapping from all-ones to 0.
- mode/a/b are sampled only on acc_fire. Values while in_ready=0 are ignored.
- Simultaneous LOAD and carry is impossible. LOAD that also clears sat_seen gives sat_seen=0 after that edge.
- No X propagation: all registers are reset; no combinational path from a/b to outputs.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, result=0, count=0, sat_seen=0; in_ready=1 after release.
2. WIDTH=8, SATURATE=1: ADD a=200 b=100, out_ready=1 -> next cycle result=255, carry=1, sat_seen=1. Repeat with SATURATE=0 -> result=44, carry=1.
3. SUB a=10 b=20 -> result=0 (SATURATE=1) or 246 (SATURATE=0), carry=1. SUB a=20 b=10 -> result=10, carry=0.
4. LOAD a=5, ACC a=7, ACC a=250, back-to-back with out_ready=1 -> results 5, 12, 255 (carry=1 on third only), count=3, sat_seen=1 after third; following LOAD a=0 -> sat_seen=0.
5. Backpressure: accept ADD 3+4, hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result=7 stable, count unchanged. Then raise out_ready with in_valid=1 ADD 1+1 -> same edge consumes 7 and loads 2, out_valid stays 1, count +1.
6. Reset mid-op: after LOAD 12 with out_valid=1 and out_ready=0, assert rst one cycle -> out_valid=0, count=0. Then ACC a=1 -> result=1, proving the accumulator was cleared.
